// File: rtl/clk_pulse_multi.sv
// Multi-channel pulse/PWM generator: shared prescaler and period counter, per-channel [start,stop) windows.
// Optional per-channel output polarity when CLK_PULSE_MULTI_POLARITY_EN is defined.
module clk_pulse_multi #(
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned COUNT_WIDTH       = 8,
  parameter int unsigned CLOCK_DELAY_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            oneshot,
  input  logic                            load,
  input  logic [CLOCK_DELAY_WIDTH-1:0]    prescale,
  input  logic [COUNT_WIDTH-1:0]          period,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] start,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] stop,
`ifdef CLK_PULSE_MULTI_POLARITY_EN
  input  logic [CHANNELS-1:0]             polarity,
`endif
  output logic [CHANNELS-1:0]             pulse,
  output logic                            wrap,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [CLOCK_DELAY_WIDTH-1:0]      pre_cnt_q, pre_cnt_d;
  logic [COUNT_WIDTH-1:0]            cnt_q, cnt_d;
  logic                              oneshot_q, oneshot_d;
  logic                              load_pending_q, load_pending_d;
  logic [CLOCK_DELAY_WIDTH-1:0]      prescale_q, prescale_d;
  logic [COUNT_WIDTH-1:0]            period_q, period_d;
  logic [CHANNELS*COUNT_WIDTH-1:0]   start_q, start_d;
  logic [CHANNELS*COUNT_WIDTH-1:0]   stop_q, stop_d;
  logic [CHANNELS-1:0]               polarity_q, polarity_d;
  logic [CHANNELS-1:0]               pulse_q, pulse_d;
  logic                              wrap_q, wrap_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  logic tick;
  logic wrap_now;
  logic capture;
  logic in_win;

  always_comb begin
    tick     = (state_q == S_RUN) && (pre_cnt_q == prescale_q);
    wrap_now = tick && (cnt_q == period_q);

    state_d        = state_q;
    pre_cnt_d      = '0;
    cnt_d          = '0;
    oneshot_d      = oneshot_q;
    load_pending_d = 1'b0;
    capture        = 1'b0;

    case (state_q)
      S_IDLE: begin
        capture = load;
        if (en) begin
          state_d   = S_RUN;
          oneshot_d = oneshot;
        end
      end
      S_RUN: begin
        if (!en) begin
          // a load still waiting for its wrap is applied on the way out to IDLE
          state_d = S_IDLE;
          capture = load || load_pending_q;
        end else begin
          capture        = wrap_now && (load || load_pending_q);
          load_pending_d = !wrap_now && (load || load_pending_q);
          if (oneshot_q && wrap_now) begin
            state_d = S_DONE;
          end else if (tick) begin
            cnt_d = wrap_now ? '0 : cnt_q + 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
            cnt_d     = cnt_q;
          end
        end
      end
      S_DONE: begin
        capture = load;
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    prescale_d = capture ? prescale : prescale_q;
    period_d   = capture ? period   : period_q;
    start_d    = capture ? start    : start_q;
    stop_d     = capture ? stop     : stop_q;
`ifdef CLK_PULSE_MULTI_POLARITY_EN
    polarity_d = capture ? polarity : polarity_q;
`else
    polarity_d = '0;
`endif

    // outputs are registered from next-state values so they line up with cnt_q
    in_win  = 1'b0;
    pulse_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      in_win = (start_d[i*COUNT_WIDTH +: COUNT_WIDTH] <= cnt_d) &&
               (cnt_d < stop_d[i*COUNT_WIDTH +: COUNT_WIDTH]);
      pulse_d[i] = (state_d == S_RUN) ? (in_win ^ polarity_d[i]) : polarity_d[i];
    end
    wrap_d = (state_d == S_RUN) && (pre_cnt_d == prescale_d) && (cnt_d == period_d);
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      oneshot_q      <= 1'b0;
      load_pending_q <= 1'b0;
      prescale_q     <= '0;
      period_q       <= '0;
      start_q        <= '0;
      stop_q         <= '0;
      polarity_q     <= '0;
      pulse_q        <= '0;
      wrap_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      oneshot_q      <= oneshot_d;
      load_pending_q <= load_pending_d;
      prescale_q     <= prescale_d;
      period_q       <= period_d;
      start_q        <= start_d;
      stop_q         <= stop_d;
      polarity_q     <= polarity_d;
      pulse_q        <= pulse_d;
      wrap_q         <= wrap_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign wrap  = wrap_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_clk_pulse_multi.sv
// Self-checking bench for clk_pulse_multi: expected {pulse,wrap,busy,done} per cycle queued, then compared.
module tb_clk_pulse_multi;
  logic        clk;
  logic        rst;
  logic        en;
  logic        oneshot;
  logic        load;
  logic [3:0]  prescale;
  logic [7:0]  period;
  logic [31:0] start;
  logic [31:0] stop;
`ifdef CLK_PULSE_MULTI_POLARITY_EN
  logic [3:0]  polarity;
`endif
  logic [3:0]  pulse;
  logic        wrap;
  logic        busy;
  logic        done;

  logic [6:0]  sb_q[$];
  int          checks;
  int          failures;

  clk_pulse_multi dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .oneshot  (oneshot),
    .load     (load),
    .prescale (prescale),
    .period   (period),
    .start    (start),
    .stop     (stop),
`ifdef CLK_PULSE_MULTI_POLARITY_EN
    .polarity (polarity),
`endif
    .pulse    (pulse),
    .wrap     (wrap),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t cycles into a steady RUN with the given config.
  function automatic logic [6:0] exp_run(input int t, input int pre, input int per,
                                         input logic [31:0] st, input logic [31:0] sp);
    int         c;
    logic [3:0] p;
    logic       w;
    c = (t / (pre + 1)) % (per + 1);
    for (int i = 0; i < 4; i++)
      p[i] = (int'(st[i*8 +: 8]) <= c) && (c < int'(sp[i*8 +: 8]));
    w = ((t % (pre + 1)) == pre) && (c == per);
    return {p, w, 1'b1, 1'b0};
  endfunction

  task automatic load_idle(input logic [3:0] pre, input logic [7:0] per,
                           input logic [31:0] st, input logic [31:0] sp);
    @(negedge clk);
    prescale = pre;
    period   = per;
    start    = st;
    stop     = sp;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got, exp;
    rst = 1'b1;
    #12;
    sb_q.push_back(7'b0);
    got = {pulse, wrap, busy, done};
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h0000_0006;
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 30; t++) sb_q.push_back(exp_run(t, 0, 9, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 31; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL basic t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 29) en = 1'b0;
    end
  endtask

  task automatic test_prescale();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h0000_0006;
    logic [6:0]  got, exp;
    load_idle(4'd3, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 85; t++) sb_q.push_back(exp_run(t, 3, 9, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 86; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL prescale t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 84) en = 1'b0;
    end
  endtask

  task automatic test_edge_windows();
    // ch0 2..6, ch1 empty (5,5), ch2 0..255 always on, ch3 inverted (7,3)
    logic [31:0] st = {8'd7, 8'd0,   8'd5, 8'd2};
    logic [31:0] sp = {8'd3, 8'd255, 8'd5, 8'd6};
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 25; t++) sb_q.push_back(exp_run(t, 0, 9, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL edge_windows t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 24) en = 1'b0;
    end
  endtask

  task automatic test_period_change();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h0000_0006;
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 25; t++)
      sb_q.push_back(t < 10 ? exp_run(t, 0, 9, st, sp) : exp_run(t - 10, 0, 4, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL period_change t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 3) begin
        period = 8'd4;
        load   = 1'b1;
      end
      if (t == 4) load = 1'b0;
      if (t == 24) en = 1'b0;
    end
  endtask

  task automatic test_pending_disable();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h0000_0006;
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 6; t++) sb_q.push_back(exp_run(t, 0, 9, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pending_disable t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 3) begin
        period = 8'd4;
        load   = 1'b1;
      end
      if (t == 4) load = 1'b0;
      if (t == 5) en = 1'b0;
    end
    // restart without a new load: the pending period of 4 must now be active
    en = 1'b1;
    for (int t = 0; t < 12; t++) sb_q.push_back(exp_run(t, 0, 4, st, sp));
    sb_q.push_back(7'b0);
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pending_restart t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 11) en = 1'b0;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h0000_0006;
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    oneshot = 1'b1;
    en      = 1'b1;
    for (int t = 0; t < 10; t++) sb_q.push_back(exp_run(t, 0, 9, st, sp));
    for (int t = 10; t < 15; t++) sb_q.push_back(7'b0000001);
    sb_q.push_back(7'b0);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL oneshot t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 0) oneshot = 1'b0;
      if (t == 14) en = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] st = 32'h0000_0002;
    logic [31:0] sp = 32'h00FF_0006;
    logic [6:0]  got, exp;
    load_idle(4'd0, 8'd9, st, sp);
    en = 1'b1;
    for (int t = 0; t < 4; t++) sb_q.push_back(exp_run(t, 0, 9, st, sp));
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL async_pre t=%0d got=%b exp=%b", t, got, exp);
      end
    end
    #2 rst = 1'b1;
    sb_q.push_back(7'b0);
    #1;
    got = {pulse, wrap, busy, done};
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    // cleared config: period 0 wraps every clk, all windows empty
    for (int t = 0; t < 5; t++) sb_q.push_back(7'b0000110);
    sb_q.push_back(7'b0);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      got = {pulse, wrap, busy, done};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL async_cleared_cfg t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 4) en = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    en       = 1'b0;
    oneshot  = 1'b0;
    load     = 1'b0;
    prescale = '0;
    period   = '0;
    start    = '0;
    stop     = '0;
`ifdef CLK_PULSE_MULTI_POLARITY_EN
    polarity = '0;
`endif
    test_reset();
    test_basic();
    test_prescale();
    test_edge_windows();
    test_period_change();
    test_pending_disable();
    test_oneshot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
